// File: rtl/oven_controller.sv
// Oven bake sequencer: latches a bake request, drives target temperature and heat
// level into the temperature model, and counts the bake time down once preheated.
module oven_controller #(
    parameter int TEMP_W        = 10,
    parameter int TIME_W        = 12,
    parameter int TICKS_PER_SEC = 1000,
    parameter int HI_BAND       = 20,
    parameter int MID_BAND      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cancel,
    input  logic [TEMP_W-1:0] set_temp,
    input  logic [TIME_W-1:0] set_time,
    input  logic [TEMP_W-1:0] current_temp,
    input  logic              preheated,
    output logic [TEMP_W-1:0] target_temp,
    output logic [1:0]        heat,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state,
    output logic              done_pulse,
    output logic              alarm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREHEAT = 2'd1,
        BAKE    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int TICK_W = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic signed [TEMP_W:0] HI_S   = (TEMP_W+1)'(HI_BAND);
    localparam logic signed [TEMP_W:0] MID_S  = (TEMP_W+1)'(MID_BAND);
    localparam logic signed [TEMP_W:0] ZERO_S = '0;

    state_t            st, st_nx;
    logic [TICK_W-1:0] tick, tick_nx;
    logic [TEMP_W-1:0] target_nx;
    logic [TIME_W-1:0] rem_nx;
    logic [1:0]        heat_nx;
    logic              accept;

    function automatic logic [1:0] heat_level(input logic [TEMP_W-1:0] tgt,
                                              input logic [TEMP_W-1:0] cur);
        logic signed [TEMP_W:0] err;
        err = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (err > HI_S)        heat_level = 2'd3;
        else if (err > MID_S)  heat_level = 2'd2;
        else if (err > ZERO_S) heat_level = 2'd1;
        else                   heat_level = 2'd0;
    endfunction

    assign accept = start && !cancel && (st == IDLE || st == DONE) &&
                    (set_temp != '0) && (set_time != '0);

    always_comb begin
        st_nx     = st;
        target_nx = target_temp;
        rem_nx    = remaining;
        tick_nx   = tick;
        if (cancel) begin
            st_nx   = IDLE;
            rem_nx  = '0;
            tick_nx = '0;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (st == DONE) rem_nx = '0;
                    if (accept) begin
                        st_nx     = PREHEAT;
                        target_nx = set_temp;
                        rem_nx    = set_time;
                        tick_nx   = '0;
                    end
                end
                PREHEAT: begin
                    if (preheated) begin
                        st_nx   = BAKE;
                        tick_nx = '0;
                    end
                end
                BAKE: begin
                    if (tick == TICK_LAST) begin
                        tick_nx = '0;
                        // Saturate at zero; reaching zero ends the bake on this edge
                        if (remaining != '0) rem_nx = remaining - TIME_W'(1);
                        if (remaining <= TIME_W'(1)) st_nx = DONE;
                    end else begin
                        tick_nx = tick + TICK_W'(1);
                    end
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    // Heat tracks the state being entered so it drops to 0 on the same edge as DONE/IDLE
    assign heat_nx = (st_nx == PREHEAT || st_nx == BAKE) ?
                     heat_level(target_nx, current_temp) : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= IDLE;
            target_temp <= '0;
            heat        <= 2'd0;
            remaining   <= '0;
            tick        <= '0;
            done_pulse  <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            st          <= st_nx;
            target_temp <= target_nx;
            heat        <= heat_nx;
            remaining   <= rem_nx;
            tick        <= tick_nx;
            done_pulse  <= (st_nx == DONE) && (st != DONE);
            alarm       <= (st_nx == DONE);
        end
    end

    assign state = st;

endmodule
